// File: rtl/consulta_linha.sv
// rtl/consulta_linha.sv - read-side membership query engine for the time-sliced Bloom line store
//
// Accepts one query at a time (line address + bit index), reads the line from
// the line SRAM, ages the bloom field to the sampled time slice (without
// writing anything back) and returns hit / live-hit count / error.
//
// Ports:
//   clk, reset_n               clock, synchronous active-low reset
//   req_valid/req_ready        query handshake; req_ready is high only when idle
//   req_addr, req_bit          line address, bit index inside each slice
//   cur_bucket, cur_loop       current time slice, sampled at accept
//   mem_rd_req/mem_rd_addr     one-cycle read strobe and held read address
//   mem_rd_vld/mem_rd_data     read data return
//   resp_valid/resp_ready      response handshake
//   resp_hit, resp_count       req_bit found in >=1 live slice, number of such slices
//   resp_err                   line timestamp ahead of current time, or read timeout
module consulta_linha #(
    parameter int DATA_WIDTH     = 72,
    parameter int NUM_BUCKETS    = 12,
    parameter int BUCKET_SZ      = 4,
    parameter int BITS_SHIFT     = $clog2(NUM_BUCKETS),
    parameter int BLOOM_INIT_POS = 16,
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT        = 64
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic [ADDR_WIDTH-1:0]                req_addr,
    input  logic [$clog2(BUCKET_SZ)-1:0]         req_bit,
    input  logic [BITS_SHIFT-1:0]                cur_bucket,
    input  logic [BLOOM_INIT_POS-BITS_SHIFT-1:0] cur_loop,
    output logic                                 mem_rd_req,
    output logic [ADDR_WIDTH-1:0]                mem_rd_addr,
    input  logic                                 mem_rd_vld,
    input  logic [DATA_WIDTH-1:0]                mem_rd_data,
    output logic                                 resp_valid,
    input  logic                                 resp_ready,
    output logic                                 resp_hit,
    output logic [$clog2(NUM_BUCKETS+1)-1:0]     resp_count,
    output logic                                 resp_err
);

    localparam int LOOP_W = BLOOM_INIT_POS - BITS_SHIFT;
    localparam int BIT_W  = $clog2(BUCKET_SZ);
    localparam int CNT_W  = $clog2(NUM_BUCKETS + 1);
    localparam int TMO_W  = $clog2(TIMEOUT);
    // Signed width wide enough for (loop diff)*NUM_BUCKETS + bucket diff.
    localparam int EW     = LOOP_W + BITS_SHIFT + 1;
    // Only header + slices are kept; anything above the last slice is ignored.
    localparam int LINE_W = BLOOM_INIT_POS + NUM_BUCKETS * BUCKET_SZ;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_WAIT,
        S_EVAL,
        S_RESP
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [BIT_W-1:0]       bit_q;
    logic [BITS_SHIFT-1:0]  cur_bucket_q;
    logic [LOOP_W-1:0]      cur_loop_q;
    logic [LINE_W-1:0]      line_q;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic                   hit_q, hit_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   err_q, err_d;
    logic                   capture_req, capture_line, load_resp;

    generate
        if (DATA_WIDTH > LINE_W) begin : g_unused_hi
            logic unused_hi;
            assign unused_hi = ^mem_rd_data[DATA_WIDTH-1:LINE_W];
        end
    endgenerate

    // Aging evaluation on the registered line.
    logic [LOOP_W-1:0]     line_loop;
    logic [BITS_SHIFT-1:0] line_bucket;
    logic signed [EW-1:0]  loop_diff, bkt_diff, elapsed;
    logic                  ahead, expired;
    logic [CNT_W-1:0]      live_cnt;

    always_comb begin
        line_loop   = line_q[LOOP_W-1:0];
        line_bucket = line_q[BLOOM_INIT_POS-1 -: BITS_SHIFT];
        loop_diff   = EW'(cur_loop_q) - EW'(line_loop);
        bkt_diff    = EW'(cur_bucket_q) - EW'(line_bucket);
        elapsed     = loop_diff * EW'(NUM_BUCKETS) + bkt_diff;
        ahead       = (cur_loop_q < line_loop) ||
                      ((cur_loop_q == line_loop) && (cur_bucket_q < line_bucket));
        expired     = (elapsed >= EW'(NUM_BUCKETS));
        live_cnt    = '0;
        // Slice j is live when it is no older than the elapsed slice count.
        for (int j = 0; j < NUM_BUCKETS; j++) begin
            if ((EW'(j) >= elapsed) && line_q[BLOOM_INIT_POS + j*BUCKET_SZ + int'(bit_q)]) begin
                live_cnt = live_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        tmo_d        = tmo_q;
        capture_req  = 1'b0;
        capture_line = 1'b0;
        load_resp    = 1'b0;
        hit_d        = 1'b0;
        count_d      = '0;
        err_d        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    capture_req = 1'b1;
                    state_d     = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Data arriving in the timeout cycle still wins.
                if (mem_rd_vld) begin
                    capture_line = 1'b1;
                    state_d      = S_EVAL;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    load_resp = 1'b1;
                    err_d     = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_EVAL: begin
                load_resp = 1'b1;
                if (ahead) begin
                    err_d = 1'b1;
                end else if (!expired) begin
                    count_d = live_cnt;
                    hit_d   = (live_cnt != '0);
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            bit_q        <= '0;
            cur_bucket_q <= '0;
            cur_loop_q   <= '0;
            line_q       <= '0;
            tmo_q        <= '0;
            hit_q        <= 1'b0;
            count_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            if (capture_req) begin
                addr_q       <= req_addr;
                bit_q        <= req_bit;
                cur_bucket_q <= cur_bucket;
                cur_loop_q   <= cur_loop;
            end
            if (capture_line) begin
                line_q <= mem_rd_data[LINE_W-1:0];
            end
            if (load_resp) begin
                hit_q   <= hit_d;
                count_q <= count_d;
                err_q   <= err_d;
            end
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign mem_rd_req  = (state_q == S_RD_REQ);
    assign mem_rd_addr = addr_q;
    assign resp_valid  = (state_q == S_RESP);
    assign resp_hit    = hit_q;
    assign resp_count  = count_q;
    assign resp_err    = err_q;

endmodule

// File: tb/tb_consulta_linha.sv
// tb/tb_consulta_linha.sv - scoreboard bench for consulta_linha
module tb_consulta_linha;
    localparam int NB  = 12;
    localparam int BS  = 4;
    localparam int BIP = 16;
    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [9:0]  req_addr;
    logic [1:0]  req_bit;
    logic [3:0]  cur_bucket;
    logic [11:0] cur_loop;
    logic        mem_rd_req;
    logic [9:0]  mem_rd_addr;
    logic        mem_rd_vld;
    logic [71:0] mem_rd_data;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_hit;
    logic [3:0]  resp_count;
    logic        resp_err;

    always #5 clk = ~clk;

    consulta_linha dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_bit     (req_bit),
        .cur_bucket  (cur_bucket),
        .cur_loop    (cur_loop),
        .mem_rd_req  (mem_rd_req),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_vld  (mem_rd_vld),
        .mem_rd_data (mem_rd_data),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_hit    (resp_hit),
        .resp_count  (resp_count),
        .resp_err    (resp_err)
    );

    typedef struct {
        logic       hit;
        logic [3:0] cnt;
        logic       err;
        int         lat;
        int         acc;
    } exp_t;

    exp_t        sb[$];
    exp_t        pend;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [71:0] mem [1024];
    int          mem_lat = 1;
    bit          mem_never = 1'b0;
    int          stray_cnt = 0;
    int          stray_done = 0;
    bit          hold_rr = 1'b0;
    bit          rr_force = 1'b0;
    int          hs_cyc = 0;
    int          acc_cyc = 0;
    bit          in_resp = 1'b0;
    bit          chk_idle = 1'b0;
    logic        h_hit;
    logic [3:0]  h_cnt;
    logic        h_err;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference: age the line to (cl, cb) and count live slices holding bit b.
    function automatic exp_t model(input logic [71:0] line, input int cl, input int cb, input int b);
        exp_t r;
        int   lp, bk, e;
        r.hit = 1'b0; r.cnt = '0; r.err = 1'b0; r.lat = 0; r.acc = 0;
        lp = int'(line[11:0]);
        bk = int'(line[15:12]);
        if (cl < lp || (cl == lp && cb < bk)) begin
            r.err = 1'b1;
        end else begin
            e = (cl - lp) * NB + (cb - bk);
            if (e < NB) begin
                for (int j = e; j < NB; j++) begin
                    if (line[BIP + j*BS + b]) r.cnt = r.cnt + 4'd1;
                end
            end
            r.hit = (r.cnt != 0);
        end
        return r;
    endfunction

    function automatic logic [71:0] mk_line(input int lp, input int bk, input logic [47:0] sl);
        logic [7:0] top;
        top = 8'($urandom);
        return {top, sl, 4'(bk), 12'(lp)};
    endfunction

    // Line memory: answers a strobe after mem_lat cycles, or never.
    initial begin
        logic [71:0] d;
        mem_rd_vld  = 1'b0;
        mem_rd_data = '0;
        forever begin
            @(negedge clk);
            if (mem_rd_req && !mem_never) begin
                d = mem[mem_rd_addr];
                repeat (mem_lat) @(posedge clk);
                #1;
                mem_rd_vld  = 1'b1;
                mem_rd_data = d;
                @(posedge clk);
                #1;
                mem_rd_vld  = 1'b0;
            end else if (stray_cnt != stray_done) begin
                @(posedge clk);
                #1;
                mem_rd_vld  = 1'b1;
                mem_rd_data = {8'hff, 32'($urandom), 32'($urandom)};
                @(posedge clk);
                #1;
                mem_rd_vld  = 1'b0;
                stray_done++;
            end
        end
    end

    initial begin
        resp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            resp_ready = hold_rr ? rr_force : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: latency, stability under backpressure, scoreboard pop on handshake.
    always @(negedge clk) begin
        if (reset_n) begin
            if (chk_idle) begin
                check("ready_after_hs", req_ready, 1);
                chk_idle = 1'b0;
            end
            if (resp_valid) begin
                check("busy_not_ready", req_ready, 0);
                if (!in_resp) begin
                    in_resp = 1'b1;
                    h_hit = resp_hit; h_cnt = resp_count; h_err = resp_err;
                    if (sb.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_resp: got resp_valid expected none (cycle %0d)", cyc);
                    end else begin
                        check("latency", cyc - sb[0].acc, sb[0].lat);
                    end
                end else begin
                    check("stable_hit", resp_hit, h_hit);
                    check("stable_cnt", resp_count, h_cnt);
                    check("stable_err", resp_err, h_err);
                end
                if (resp_ready) begin
                    if (sb.size() != 0) begin
                        check("resp_hit", resp_hit, sb[0].hit);
                        check("resp_count", resp_count, sb[0].cnt);
                        check("resp_err", resp_err, sb[0].err);
                        void'(sb.pop_front());
                    end
                    in_resp  = 1'b0;
                    chk_idle = 1'b1;
                    hs_cyc   = cyc;
                end
            end
        end
    end

    task automatic start_req(input logic [9:0] a, input logic [71:0] line, input int cl, input int cb,
                             input int b, input int lat, input bit never);
        mem[a]    = line;
        mem_lat   = lat;
        mem_never = never;
        pend      = model(line, cl, cb, b);
        if (never) begin
            pend.hit = 1'b0; pend.cnt = '0; pend.err = 1'b1;
            pend.lat = 2 + TMO;
        end else begin
            pend.lat = 3 + lat;
        end
        req_addr   = a;
        req_bit    = 2'(b);
        cur_loop   = 12'(cl);
        cur_bucket = 4'(cb);
        req_valid  = 1'b1;
    endtask

    task automatic wait_accept();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 300) begin
                tests++; fails++;
                $display("FAIL accept_timeout: got no accept expected accept within 300 cycles");
                req_valid = 1'b0;
                return;
            end
        end
        pend.acc = cyc;
        acc_cyc  = cyc;
        sb.push_back(pend);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            tests++; fails++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_query(input logic [9:0] a, input logic [71:0] line, input int cl, input int cb,
                            input int b, input int lat, input bit never);
        start_req(a, line, cl, cb, b, lat, never);
        wait_accept();
        wait_drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cl, cb, lp, bk;
        reset_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_bit = '0;
        cur_bucket = '0; cur_loop = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_mem_rd_req", mem_rd_req, 0);
        check("rst_mem_rd_addr", mem_rd_addr, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_hit", resp_hit, 0);
        check("rst_resp_count", resp_count, 0);
        check("rst_resp_err", resp_err, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // fresh line, all slices live
        do_query(10'd17, mk_line(5, 3, {12{4'b0001}}), 5, 3, 0, 1, 1'b0);
        // partial aging
        do_query(10'd18, mk_line(5, 3, {12{4'b0100}}), 5, 10, 2, 1, 1'b0);
        do_query(10'd18, mk_line(5, 3, {12{4'b0100}}), 5, 10, 0, 2, 1'b0);
        // loop wrap, then fully expired
        do_query(10'd19, mk_line(5, 10, {12{4'b1000}}), 6, 2, 3, 1, 1'b0);
        do_query(10'd20, mk_line(5, 10, {16'h0000, 32'($urandom)}), 6, 2, 1, 3, 1'b0);
        do_query(10'd21, mk_line(5, 10, {12{4'b1111}}), 7, 0, 1, 1, 1'b0);
        // timestamp ahead
        do_query(10'd22, mk_line(6, 0, {12{4'b1111}}), 5, 11, 0, 1, 1'b0);
        do_query(10'd23, mk_line(5, 8, {12{4'b1111}}), 5, 2, 0, 1, 1'b0);
        // read timeout
        do_query(10'd24, mk_line(1, 1, {12{4'b1111}}), 1, 1, 0, 1, 1'b1);

        // backpressure: hold resp_ready low, second request queued behind it
        @(negedge clk);
        hold_rr = 1'b1; rr_force = 1'b0;
        @(posedge clk);
        #1;
        start_req(10'd30, mk_line(9, 4, {12{4'b0010}}), 9, 6, 1, 2, 1'b0);
        wait_accept();
        n = 0;
        while (!resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_resp_seen", resp_valid, 1);
        repeat (10) @(negedge clk);
        rr_force = 1'b1;
        start_req(10'd31, mk_line(9, 4, {12{4'b0110}}), 10, 1, 2, 1, 1'b0);
        wait_accept();
        check("bp_accept_cycle", acc_cyc, hs_cyc + 1);
        wait_drain();
        hold_rr = 1'b0;

        // reset in WAIT, stray read data afterwards
        start_req(10'd40, mk_line(2, 2, {12{4'b1111}}), 2, 2, 0, 1, 1'b1);
        wait_accept();
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        sb.delete();
        in_resp = 1'b0; chk_idle = 1'b0;
        stray_cnt++;
        repeat (6) begin
            @(negedge clk);
            check("rr_resp_valid", resp_valid, 0);
            check("rr_req_ready", req_ready, 1);
        end
        check("rr_mem_rd_req", mem_rd_req, 0);
        check("rr_mem_rd_addr", mem_rd_addr, 0);
        check("rr_resp_hit", resp_hit, 0);
        check("rr_resp_count", resp_count, 0);
        check("rr_resp_err", resp_err, 0);
        mem_never = 1'b0;
        @(posedge clk);
        #1;

        // randomized queries near the current time
        for (int i = 0; i < 150; i++) begin
            cl = int'($urandom_range(0, 4095));
            cb = int'($urandom_range(0, 11));
            if ($urandom_range(0, 9) == 0) lp = (cl + 1) % 4096;
            else lp = cl - int'($urandom_range(0, 2));
            if (lp < 0) lp = lp + 4096;
            bk = int'($urandom_range(0, 11));
            do_query(10'($urandom), mk_line(lp, bk, {16'($urandom), 32'($urandom)}), cl, cb,
                     int'($urandom_range(0, 3)), int'($urandom_range(1, 4)),
                     ($urandom_range(0, 39) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
